vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, meaning the vertical equivalents in lines.
REQ-006 The block SHALL have parameters H_POL and V_POL, default 0, where 0 means the sync output is active-low and 1 means active-high.
REQ-007 The block SHALL have a derived localparam H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, a derived localparam V_TOTAL likewise, a derived localparam X_W = clog2(H_TOTAL), and a derived localparam Y_W = clog2(V_TOTAL).
REQ-008 The block SHALL have port i_clk, input, 1 bit, the base clock.
REQ-009 The block SHALL have port i_rst, input, 1 bit, a synchronous, active-high reset.
REQ-010 The block SHALL have port i_pix_stb, input, 1 bit, a one-i_clk pixel advance strobe.
REQ-011 The block SHALL have ports o_hs and o_vs, output, 1 bit each, horizontal and vertical sync, with polarity set by H_POL/V_POL.
REQ-012 The block SHALL have port o_active, output, 1 bit, high while the current position is inside the visible area.
REQ-013 The block SHALL have port o_blanking, output, 1 bit, equal to ~o_active at all times.
REQ-014 The block SHALL have port o_line_start, output, 1 bit, a one-cycle pulse at the start of each line.
REQ-015 The block SHALL have port o_frame_start, output, 1 bit, a one-cycle pulse at the start of each frame.
REQ-016 The block SHALL have port o_animate, output, 1 bit, a one-cycle pulse on entering the first vertical-blanking line.
REQ-017 The block SHALL have ports o_x and o_y, output, X_W and Y_W bits, giving the visible pixel coordinates.
REQ-018 The block SHALL have port o_frame_cnt, output, 16 bits, a free-running frame counter.

Function
REQ-019 The horizontal counter SHALL run 0..H_TOTAL-1, ordered active, front porch, sync, back porch, and SHALL advance only on cycles with i_pix_stb=1.
REQ-020 On the strobe where h=H_TOTAL-1, h SHALL wrap to 0 and v SHALL increment; when v is also V_TOTAL-1, v SHALL wrap to 0.
REQ-021 v SHALL never hold V_TOTAL, and h SHALL never hold H_TOTAL.
REQ-022 Sync SHALL be asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and the vertical equivalent SHALL apply in lines.
REQ-023 o_active SHALL equal (h<H_ACTIVE)&&(v<V_ACTIVE).
REQ-024 o_x SHALL equal h when h<H_ACTIVE and 0 otherwise; o_y SHALL equal v when v<V_ACTIVE and 0 otherwise.
REQ-025 All outputs SHALL be registers, updated on the same edge as the counters and decoded from the post-edge count, giving zero skew between outputs and one i_clk of latency from the strobe.
REQ-026 o_line_start SHALL be high for exactly one i_clk following the edge where h wraps to 0.
REQ-027 o_frame_start SHALL be high for exactly one i_clk following the edge where h and v both wrap to 0, coincident with o_line_start.
REQ-028 o_animate SHALL be high for exactly one i_clk following the edge entering (h=0, v=V_ACTIVE).
REQ-029 o_frame_cnt SHALL increment by 1 on each o_frame_start edge and wrap from 0xFFFF to 0.
REQ-030 With i_pix_stb held at 0, counters and all level outputs SHALL hold, and all pulse outputs SHALL be 0.
REQ-031 Elaboration SHALL fail if any timing parameter is less than 1.

Reset
REQ-032 While i_rst=1, h, v and o_frame_cnt SHALL be 0 regardless of i_pix_stb, since reset has priority.
REQ-033 Reset outputs SHALL be: o_x=0, o_y=0, o_active=1, o_blanking=0, o_hs=~H_POL, o_vs=~V_POL, and all pulses 0.
REQ-034 Reset asserted mid-line or mid-frame SHALL restart at (0,0) on the next edge, and the first strobe after reset release SHALL move to h=1.

Structure
REQ-035 Package vga_timing_pkg SHALL hold the 640x480@60, 800x600@60 and 1280x720@60 timing constant sets and a clog2 function.
REQ-036 One sub-module, vga_axis_counter, SHALL be instantiated twice: it takes parameters ACTIVE/FP/SYNC/BP/POL, inputs en, rst and clk, and outputs count, sync, active and wrap.

Verification
REQ-037 A default-parameter run of 2 frames SHALL give 800 strobes per line, 525 lines, an o_hs low width of 96 strobes beginning at h=656, and an o_vs low width of 2 lines beginning at v=490.
REQ-038 A boundary check SHALL give, at the h=799, v=524 strobe: next h=0, v=0, o_frame_start=1 and o_line_start=1 for one cycle, and o_frame_cnt+1.
REQ-039 With i_pix_stb=1 once every 4 clocks, every pulse SHALL be 1 clock wide, and outputs SHALL hold between strobes.
REQ-040 i_rst asserted at h=300, v=200 SHALL give, next edge, h=0, v=0 and o_frame_cnt=0, and reset asserted together with i_pix_stb SHALL win.
REQ-041 With H_POL=V_POL=1 and 1280x720 package timing, sync SHALL be active-high and H_TOTAL=1650, V_TOTAL=750.
REQ-042 o_animate SHALL occur once per frame, at v=480, h=0, and o_active SHALL be 0 for the whole of lines 480..524.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constant sets and width helper
package vga_timing_pkg;

   // 640x480 @ 60 Hz (25.175 MHz pixel clock)
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;

   // 800x600 @ 60 Hz (40 MHz pixel clock)
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;

   // 1280x720 @ 60 Hz (74.25 MHz pixel clock), syncs normally active-high
   localparam int HD1280_H_ACTIVE = 1280;
   localparam int HD1280_H_FP     = 110;
   localparam int HD1280_H_SYNC   = 40;
   localparam int HD1280_H_BP     = 220;
   localparam int HD1280_V_ACTIVE = 720;
   localparam int HD1280_V_FP     = 5;
   localparam int HD1280_V_SYNC   = 5;
   localparam int HD1280_V_BP     = 20;

   // Bits needed to hold values 0..value-1
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with sync and active decode
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int POL    = 0,
   localparam int TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int W     = clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         sync,
   output logic         active,
   output logic         wrap
);

   if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
      $error("vga_axis_counter: every timing parameter must be at least 1");
   end

   logic [W-1:0] count_q, count_d;
   logic         sync_q, sync_d;

   // wrap flags the advance that takes the last position back to 0
   assign wrap = en && (count_q == W'(TOTAL - 1));

   // Next position; reset wins over the advance
   always_comb begin
      count_d = count_q;
      if (rst) begin
         count_d = '0;
      end else if (wrap) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
      sync_d = ((count_d >= W'(ACTIVE + FP)) && (count_d < W'(ACTIVE + FP + SYNC)))
               ? 1'(POL) : ~1'(POL);
   end

   // active describes the position being loaded on this edge so the parent
   // can register its own outputs in step with the counter
   assign active = (count_d < W'(ACTIVE));

   // Position and sync registered from the post-edge count
   always_ff @(posedge clk) begin
      count_q <= count_d;
      sync_q  <= sync_d;
   end

   assign count = count_q;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered outputs
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int X_W     = clog2(H_TOTAL),
   localparam int Y_W     = clog2(V_TOTAL)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_pix_stb,
   output logic           o_hs,
   output logic           o_vs,
   output logic           o_active,
   output logic           o_blanking,
   output logic           o_line_start,
   output logic           o_frame_start,
   output logic           o_animate,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic [15:0]    o_frame_cnt
);

   logic [X_W-1:0] h_count;
   logic [Y_W-1:0] v_count;
   logic           h_sync, v_sync;
   logic           h_act_nxt, v_act_nxt;
   logic           h_wrap, v_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (H_POL)
   ) u_h_axis (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (i_pix_stb),
      .count  (h_count),
      .sync   (h_sync),
      .active (h_act_nxt),
      .wrap   (h_wrap)
   );

   // The line counter steps once per horizontal wrap
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (V_POL)
   ) u_v_axis (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (h_wrap),
      .count  (v_count),
      .sync   (v_sync),
      .active (v_act_nxt),
      .wrap   (v_wrap)
   );

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           active_q, active_d;
   logic           blanking_q;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;
   logic           animate_q, animate_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;

   // Decode the outputs for the position the counters move to on this edge
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      active_d      = h_act_nxt && v_act_nxt;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      animate_d     = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      if (i_rst) begin
         x_d         = '0;
         y_d         = '0;
         frame_cnt_d = '0;
      end else begin
         line_start_d  = h_wrap;
         frame_start_d = v_wrap;
         animate_d     = h_wrap && (v_count == Y_W'(V_ACTIVE - 1));
         if (i_pix_stb) begin
            x_d = (h_act_nxt && !h_wrap) ? h_count + 1'b1 : '0;
         end
         if (h_wrap) begin
            y_d = (v_act_nxt && !v_wrap) ? v_count + 1'b1 : '0;
         end
         if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end
   end

   // Output registers share the counters' edge so all outputs are skew-free
   always_ff @(posedge i_clk) begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      blanking_q    <= ~active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      animate_q     <= animate_d;
      frame_cnt_q   <= frame_cnt_d;
   end

   assign o_hs          = h_sync;
   assign o_vs          = v_sync;
   assign o_active      = active_q;
   assign o_blanking    = blanking_q;
   assign o_line_start  = line_start_q;
   assign o_frame_start = frame_start_q;
   assign o_animate     = animate_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_cnt   = frame_cnt_q;

endmodule
